mul_arb: RTL and testbench

MUL_ARB -- requirements
Module: mul_arb

---
 rtl/mul_arb_if.sv | 27 ++
 rtl/mul_arb.sv | 138 +++++++++++++
 tb/tb_mul_arb.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mul_arb_if.sv
// Bundle of requester handshakes, result ports and shared-multiplier ports for mul_arb.
// slave = arbiter side, master = requesters plus the external multiplier.
interface mul_arb_if;
   logic        r0_req,    r1_req;
   logic        r0_ack,    r1_ack;
   logic [26:0] r0_a,      r0_b;
   logic [26:0] r1_a,      r1_b;
   logic        r0_rvalid, r1_rvalid;
   logic        r0_rready, r1_rready;
   logic [53:0] r0_rslt,   r1_rslt;
   logic        mul_en;
   logic [26:0] mul_in_1,  mul_in_2;
   logic [53:0] mul_out;
   logic [31:0] stat_cnt;

   modport slave (
      input  r0_req, r1_req, r0_a, r0_b, r1_a, r1_b, r0_rready, r1_rready, mul_out,
      output r0_ack, r1_ack, r0_rvalid, r1_rvalid, r0_rslt, r1_rslt,
      output mul_en, mul_in_1, mul_in_2, stat_cnt
   );

   modport master (
      output r0_req, r1_req, r0_a, r0_b, r1_a, r1_b, r0_rready, r1_rready, mul_out,
      input  r0_ack, r1_ack, r0_rvalid, r1_rvalid, r0_rslt, r1_rslt,
      input  mul_en, mul_in_1, mul_in_2, stat_cnt
   );
endinterface

// File: rtl/mul_arb.sv
// Two-requester round-robin front end for a shared pipelined 27x27 multiplier with
// per-requester credit-protected FWFT result FIFOs. Define MUL_ARB_STAT_EN for the grant counter.
module mul_arb #(
   parameter int unsigned MUL_LAT    = 2,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input logic      clk,
   input logic      reset,
   mul_arb_if.slave bus
);
   localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

   logic [1:0]   req, rready, elig, gnt, push, pop, rvalid;
   logic [CW-1:0] credit_q [2];
   logic [CW-1:0] credit_d [2];
   logic [AW:0]   wptr_q [2];
   logic [AW:0]   wptr_d [2];
   logic [AW:0]   rptr_q [2];
   logic [AW:0]   rptr_d [2];
   logic [53:0]   mem_q [2][2**AW];
   logic          last_q, last_d;  // 1: r1 was granted most recently
   logic [MUL_LAT-1:0] vld_q, vld_d, id_q, id_d;
   logic          fin, fin_id;

   assign req    = {bus.r1_req, bus.r0_req};
   assign rready = {bus.r1_rready, bus.r0_rready};

   always_comb begin
      elig = '0;
      gnt  = '0;
      for (int n = 0; n < 2; n++) begin
         elig[n] = req[n] && (credit_q[n] < CW'(FIFO_DEPTH));
      end
      if (!reset) begin
         gnt[0] = elig[0] && (!elig[1] || last_q);
         gnt[1] = elig[1] && (!elig[0] || !last_q);
      end
      last_d = last_q;
      if (gnt[0]) begin
         last_d = 1'b0;
      end else if (gnt[1]) begin
         last_d = 1'b1;
      end
   end

   // Issue tracker mirrors the multiplier pipeline so the product lands in the right FIFO.
   always_comb begin
      vld_d    = '0;
      id_d     = '0;
      vld_d[0] = |gnt;
      id_d[0]  = gnt[1];
      for (int i = 1; i < int'(MUL_LAT); i++) begin
         vld_d[i] = vld_q[i-1];
         id_d[i]  = id_q[i-1];
      end
   end

   assign fin    = vld_q[MUL_LAT-1];
   assign fin_id = id_q[MUL_LAT-1];
   assign push   = {fin && fin_id, fin && !fin_id};

   always_comb begin
      rvalid = '0;
      pop    = '0;
      for (int n = 0; n < 2; n++) begin
         rvalid[n]   = (wptr_q[n] != rptr_q[n]);
         pop[n]      = rvalid[n] && rready[n];
         wptr_d[n]   = wptr_q[n] + (AW + 1)'(push[n]);
         rptr_d[n]   = rptr_q[n] + (AW + 1)'(pop[n]);
         credit_d[n] = credit_q[n];
         if (gnt[n] && !pop[n]) begin
            credit_d[n] = credit_q[n] + CW'(1);
         end else if (!gnt[n] && pop[n]) begin
            credit_d[n] = credit_q[n] - CW'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         last_q <= 1'b1;
         vld_q  <= '0;
         id_q   <= '0;
         for (int n = 0; n < 2; n++) begin
            credit_q[n] <= '0;
            wptr_q[n]   <= '0;
            rptr_q[n]   <= '0;
         end
      end else begin
         last_q <= last_d;
         vld_q  <= vld_d;
         id_q   <= id_d;
         for (int n = 0; n < 2; n++) begin
            credit_q[n] <= credit_d[n];
            wptr_q[n]   <= wptr_d[n];
            rptr_q[n]   <= rptr_d[n];
         end
      end
   end

   // Storage needs no reset: occupancy lives entirely in the pointers.
   always_ff @(posedge clk) begin
      for (int n = 0; n < 2; n++) begin
         if (push[n]) begin
            mem_q[n][wptr_q[n][AW-1:0]] <= bus.mul_out;
         end
      end
   end

   assign bus.r0_ack    = gnt[0];
   assign bus.r1_ack    = gnt[1];
   assign bus.mul_en    = |gnt;
   assign bus.mul_in_1  = gnt[0] ? bus.r0_a : (gnt[1] ? bus.r1_a : '0);
   assign bus.mul_in_2  = gnt[0] ? bus.r0_b : (gnt[1] ? bus.r1_b : '0);
   assign bus.r0_rvalid = rvalid[0];
   assign bus.r1_rvalid = rvalid[1];
   assign bus.r0_rslt   = rvalid[0] ? mem_q[0][rptr_q[0][AW-1:0]] : '0;
   assign bus.r1_rslt   = rvalid[1] ? mem_q[1][rptr_q[1][AW-1:0]] : '0;

`ifdef MUL_ARB_STAT_EN
   logic [31:0] stat_q, stat_d;

   assign stat_d = stat_q + {31'b0, |gnt};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stat_q <= '0;
      end else begin
         stat_q <= stat_d;
      end
   end

   assign bus.stat_cnt = stat_q;
`else
   assign bus.stat_cnt = '0;
`endif
endmodule

// File: tb/tb_mul_arb.sv
// Scoreboard bench for mul_arb: grants push hand-computed products, a monitor pops and
// compares every accepted result. Also models the external 2-cycle multiplier.
module tb_mul_arb;
   logic clk = 1'b0;
   logic reset;
   int   errors = 0;
   int   checks = 0;

`ifdef MUL_ARB_STAT_EN
   localparam logic [31:0] StatExp = 32'd10;
`else
   localparam logic [31:0] StatExp = 32'd0;
`endif

   mul_arb_if bus ();

   mul_arb #(.MUL_LAT(2), .FIFO_DEPTH(4)) dut (.clk(clk), .reset(reset), .bus(bus));

   always #5 clk = ~clk;

   // External multiplier, two register stages.
   logic [53:0] p1, p2;
   always @(posedge clk) begin
      p1 <= bus.mul_en ? 54'(bus.mul_in_1) * 54'(bus.mul_in_2) : '0;
      p2 <= p1;
   end
   assign bus.mul_out = p2;

   logic [53:0] exp0 [$];
   logic [53:0] exp1 [$];
   logic [53:0] cur_exp0, cur_exp1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   // Monitor: issue side pushes expectations, result side pops and compares.
   always @(negedge clk) begin
      logic [53:0] e;
      if (!reset) begin
         if (bus.r0_rvalid && bus.r0_rready) begin
            if (exp0.size() == 0) check("r0 unexpected result", 64'(bus.r0_rslt), 64'hdead);
            else begin
               e = exp0.pop_front();
               check("r0 rslt", 64'(bus.r0_rslt), 64'(e));
            end
         end
         if (bus.r1_rvalid && bus.r1_rready) begin
            if (exp1.size() == 0) check("r1 unexpected result", 64'(bus.r1_rslt), 64'hdead);
            else begin
               e = exp1.pop_front();
               check("r1 rslt", 64'(bus.r1_rslt), 64'(e));
            end
         end
         check("mul_en vs acks", 64'(bus.mul_en), 64'(bus.r0_ack | bus.r1_ack));
         if (bus.r0_req && bus.r0_ack) begin
            exp0.push_back(cur_exp0);
            check("r0 mul_in_1", 64'(bus.mul_in_1), 64'(bus.r0_a));
            check("r0 mul_in_2", 64'(bus.mul_in_2), 64'(bus.r0_b));
         end else if (bus.r1_req && bus.r1_ack) begin
            exp1.push_back(cur_exp1);
            check("r1 mul_in_1", 64'(bus.mul_in_1), 64'(bus.r1_a));
            check("r1 mul_in_2", 64'(bus.mul_in_2), 64'(bus.r1_b));
         end else begin
            check("idle mul_in", 64'({bus.mul_in_1, bus.mul_in_2}), 64'd0);
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      exp0.delete();
      exp1.delete();
      cyc();
      cyc();
      reset = 1'b0;
   endtask

   task automatic issue(input int n, input logic [26:0] a, input logic [26:0] b,
                        input logic [53:0] e);
      bit got = 0;
      if (n == 0) begin
         bus.r0_a = a; bus.r0_b = b; cur_exp0 = e; bus.r0_req = 1'b1;
      end else begin
         bus.r1_a = a; bus.r1_b = b; cur_exp1 = e; bus.r1_req = 1'b1;
      end
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clk);
         got = (n == 0) ? bus.r0_ack : bus.r1_ack;
         cyc();
      end
      if (!got) check("issue ack timeout", 64'd0, 64'd1);
      bus.r0_req = 1'b0;
      bus.r1_req = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 50 && (exp0.size() + exp1.size()) != 0; i++) cyc();
      check("drain r0 left", 64'(exp0.size()), 64'd0);
      check("drain r1 left", 64'(exp1.size()), 64'd0);
   endtask

   initial begin
      int cnt;
      bit seen;
      reset = 1'b1;
      bus.r0_req = 1'b1; bus.r1_req = 1'b1;
      bus.r0_a = 27'd9; bus.r0_b = 27'd9; bus.r1_a = 27'd8; bus.r1_b = 27'd8;
      bus.r0_rready = 1'b1; bus.r1_rready = 1'b1;
      cur_exp0 = '0; cur_exp1 = '0;
      cyc();
      @(negedge clk);
      check("reset acks", 64'({bus.r0_ack, bus.r1_ack}), 64'd0);
      check("reset mul_en", 64'(bus.mul_en), 64'd0);
      check("reset mul_in", 64'({bus.mul_in_1, bus.mul_in_2}), 64'd0);
      check("reset rvalid", 64'({bus.r0_rvalid, bus.r1_rvalid}), 64'd0);
      check("reset rslt r0", 64'(bus.r0_rslt), 64'd0);
      check("reset rslt r1", 64'(bus.r1_rslt), 64'd0);
      check("reset stat_cnt", 64'(bus.stat_cnt), 64'd0);
      cyc();
      bus.r0_req = 1'b0; bus.r1_req = 1'b0;
      reset = 1'b0;

      // Single issue, latency MUL_LAT+1 to rvalid
      cyc();
      bus.r0_a = 27'd3; bus.r0_b = 27'd5; cur_exp0 = 54'd15; bus.r0_req = 1'b1;
      @(negedge clk);
      check("single ack", 64'(bus.r0_ack), 64'd1);
      cyc();
      bus.r0_req = 1'b0;
      @(negedge clk);
      check("single rvalid T+1", 64'(bus.r0_rvalid), 64'd0);
      cyc();
      @(negedge clk);
      check("single rvalid T+2", 64'(bus.r0_rvalid), 64'd0);
      cyc();
      @(negedge clk);
      check("single rvalid T+3", 64'(bus.r0_rvalid), 64'd1);
      check("single rslt T+3", 64'(bus.r0_rslt), 64'd15);
      cyc();

      // (2^27-1)^2 = 2^54 - 2^28 + 1
      issue(1, 27'h7FFFFFF, 27'h7FFFFFF, 54'h3FFFFFF0000001);
      drain();

      // Contention from reset: r0, r1, r0, r1
      do_reset();
      bus.r0_a = 27'd2; bus.r0_b = 27'd7; cur_exp0 = 54'd14;
      bus.r1_a = 27'd4; bus.r1_b = 27'd4; cur_exp1 = 54'd16;
      bus.r0_req = 1'b1; bus.r1_req = 1'b1;
      @(negedge clk);
      check("cont c0 acks", 64'({bus.r0_ack, bus.r1_ack}), 64'b10);
      cyc();
      bus.r0_a = 27'd6; bus.r0_b = 27'd9; cur_exp0 = 54'd54;
      @(negedge clk);
      check("cont c1 acks", 64'({bus.r0_ack, bus.r1_ack}), 64'b01);
      cyc();
      bus.r1_a = 27'd10; bus.r1_b = 27'd11; cur_exp1 = 54'd110;
      @(negedge clk);
      check("cont c2 acks", 64'({bus.r0_ack, bus.r1_ack}), 64'b10);
      cyc();
      bus.r0_a = 27'd12; bus.r0_b = 27'd13; cur_exp0 = 54'd156;
      @(negedge clk);
      check("cont c3 acks", 64'({bus.r0_ack, bus.r1_ack}), 64'b01);
      cyc();
      bus.r0_req = 1'b0; bus.r1_req = 1'b0;
      drain();

      // Backpressure on r1: four credits, then one more after a single pop
      bus.r1_rready = 1'b0;
      bus.r1_a = 27'd123; bus.r1_b = 27'd456; cur_exp1 = 54'd56088; bus.r1_req = 1'b1;
      cnt = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (bus.r1_ack) cnt++;
         cyc();
      end
      check("bp grants", 64'(cnt), 64'd4);
      @(negedge clk);
      check("bp stalled ack", 64'(bus.r1_ack), 64'd0);
      bus.r1_rready = 1'b1;
      cyc();
      bus.r1_rready = 1'b0;
      cnt = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (bus.r1_ack) cnt++;
         cyc();
      end
      check("bp grants after pop", 64'(cnt), 64'd1);
      bus.r1_req = 1'b0;
      bus.r1_rready = 1'b1;
      drain();

      // Reset one cycle after two grants discards everything in flight
      bus.r0_a = 27'd100; bus.r0_b = 27'd200; cur_exp0 = 54'd20000;
      bus.r1_a = 27'd300; bus.r1_b = 27'd400; cur_exp1 = 54'd120000;
      bus.r0_req = 1'b1; bus.r1_req = 1'b1;
      @(negedge clk);
      check("mid g1 r0", 64'(bus.r0_ack), 64'd1);
      cyc();
      bus.r0_req = 1'b0;
      @(negedge clk);
      check("mid g2 r1", 64'(bus.r1_ack), 64'd1);
      cyc();
      bus.r1_req = 1'b0;
      do_reset();
      seen = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (bus.r0_rvalid || bus.r1_rvalid) seen = 1;
         cyc();
      end
      check("no rvalid after reset", 64'(seen), 64'd0);
      check("stat after reset", 64'(bus.stat_cnt), 64'd0);

      // Credits restarted at zero: r0 takes a full four before stalling
      bus.r0_rready = 1'b0;
      bus.r0_a = 27'd7; bus.r0_b = 27'd8; cur_exp0 = 54'd56; bus.r0_req = 1'b1;
      cnt = 0;
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         if (bus.r0_ack) cnt++;
         cyc();
      end
      check("credits after reset", 64'(cnt), 64'd4);
      bus.r0_req = 1'b0;
      bus.r0_rready = 1'b1;
      drain();

      issue(0, 27'd1, 27'd1, 54'd1);
      issue(1, 27'd2, 27'd3, 54'd6);
      issue(0, 27'h4000000, 27'd2, 54'h8000000);
      issue(1, 27'd1000, 27'd1000, 54'd1000000);
      issue(0, 27'd0, 27'h5555555, 54'd0);
      issue(1, 27'd17, 27'd19, 54'd323);
      drain();
      check("stat_cnt after 10 grants", 64'(bus.stat_cnt), 64'(StatExp));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end
endmodule
